cpu_boot_ctrl: RTL and testbench
================================

// Module: cpu_boot_ctrl
// PURPOSE
//  Sequencer that sits beside cpu and drives its external memory ports and enable.
//  On start it streams a program into instruction memory, then initial data into data memory.
//  It then runs the core for a fixed number of cycles and streams a data-memory window back out.
//  It is the single owner of the *_ext / *_ext_2 ports and of cpu enable.
// PARAMETERS
//  IMEM_WORDS  512   instruction memory depth in words (ADDR_W 9)
//  DMEM_WORDS  1024  data memory depth in words (ADDR_W 10)
//  RD_LAT      1     cycles from ren_ext_2 to valid rdata_ext_2
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  start        in   1   begin sequence; sampled only in IDLE
//  imem_len     in   10  words to load into IMEM
//  dmem_len     in   11  words to load into DMEM
//  run_cycles   in   32  cycles cpu_enable stays high
//  dump_len     in   11  DMEM words to read back, from word 0
//  s_valid      in   1   load stream valid
//  s_ready      out  1   load stream ready
//  s_data       in   32  load stream word
//  m_valid      out  1   dump stream valid
//  m_ready      in   1   dump stream ready
//  m_data       out  32  dump stream word
//  cpu_enable   out  1   to cpu enable
//  addr_ext, wen_ext, ren_ext, wdata_ext   out 32/1/1/32   IMEM external port
//  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2   out 32/1/1/32   DMEM external port
//  rdata_ext_2  in   32  DMEM external read data
//  busy         out  1   high in every state except IDLE
//  done         out  1   sticky; set on sequence completion, cleared by accepted start
// BEHAVIOUR
//  - Single clock (clk); rst is synchronous and active-high.
//  - Reset:
//    - State goes to IDLE.
//    - All outputs 0, and all counters and latched lengths 0.
//    - Memory contents are not touched.
//  - States: IDLE -> LOAD_I -> LOAD_D -> RUN -> DUMP -> IDLE.
//    - A phase whose length is 0 is skipped in the same transition.
//    - All phases zero: done rises 1 cycle after start.
//  - IDLE:
//    - start=1 latches imem_len, dmem_len, run_cycles and dump_len, and clears done.
//    - start is ignored in all other states.
//  - Length clamps, applied at latch:
//    - imem_len is clamped to IMEM_WORDS.
//    - dmem_len and dump_len are clamped to DMEM_WORDS.
//  - LOAD_I / LOAD_D:
//    - s_ready=1; it is 0 in all other states.
//    - Word k is accepted on s_valid&s_ready.
//    - Writes are registered. The cycle after the handshake: wen_ext (or wen_ext_2)=1, addr=k<<2 (byte address), wdata=the accepted word.
//    - After the last handshake the state advances. The trailing write still issues on the next cycle.
//    - s_valid low inserts bubbles with no write.
//  - RUN:
//    - cpu_enable=1 for exactly run_cycles consecutive cycles, then 0, then go to DUMP.
//    - No *_ext strobes are active during RUN.
//  - DUMP, word j:
//    - Issue ren_ext_2=1 with addr_ext_2=j<<2 for one cycle.
//    - After RD_LAT cycles capture rdata_ext_2 into m_data and raise m_valid.
//    - m_data is held stable until m_ready. Only one read is outstanding at a time.
//    - After the last word is accepted, go to IDLE with done=1.
//  - wen_ext/wen_ext_2 and ren_ext/ren_ext_2 are never asserted together. ren_ext is always 0.
//  - rst mid-phase: at the next edge cpu_enable, all strobes and m_valid drop and state is IDLE. Partially loaded memory is left as is.
// TESTING
//  - Load: imem_len=3, dmem_len=2, run_cycles=0, dump_len=0; stream A,B,C,D,E back-to-back.
//    Expect: IMEM writes at 0x0,0x4,0x8; DMEM writes at 0x0,0x4; done high; zero cpu_enable cycles.
//  - Backpressure: dump_len=4 with DMEM = 10,20,30,40; m_ready toggling 1010.
//    Expect: m_data 10,20,30,40 in order, each held stable while m_ready=0.
//  - Run window: run_cycles=5.
//    Expect: cpu_enable high exactly 5 cycles, and the counter of a loaded addi-loop program matches.
//  - Clamp: imem_len=600 (out-of-range).
//    Expect: exactly 512 writes, last at addr 0x7FC, then LOAD_D.
//  - Reset mid-RUN: rst at the 3rd RUN cycle.
//    Expect: cpu_enable=0 next cycle, busy=0, done=0; a new start works.
//  - Start ignored: start pulsed during LOAD_D.
//    Expect: lengths unchanged and sequence unchanged.

Source files
------------

// File: rtl/cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_boot_ctrl
//
// Boot sequencer that sits beside the cpu and owns its external memory ports
// and its enable. After a start it streams a program into instruction memory,
// then initial data into data memory, lets the core run for a fixed number of
// cycles, and finally streams a window of data memory (from word 0) back out.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin a sequence (only looked at in IDLE)
//   imem_len_i            words to load into IMEM (clamped to IMEM_WORDS)
//   dmem_len_i            words to load into DMEM (clamped to DMEM_WORDS)
//   run_cycles_i          cycles cpu_enable_o stays high
//   dump_len_i            DMEM words to read back (clamped to DMEM_WORDS)
//   s_valid_i/s_ready_o/s_data_i   load stream (IMEM words, then DMEM words)
//   m_valid_o/m_ready_i/m_data_o   dump stream
//   cpu_enable_o          cpu enable
//   addr_ext_o, wen_ext_o, ren_ext_o, wdata_ext_o              IMEM port
//   addr_ext_2_o, wen_ext_2_o, ren_ext_2_o, wdata_ext_2_o      DMEM port
//   rdata_ext_2_i         DMEM read data, valid RD_LAT cycles after a read
//   busy_o                high whenever the sequencer is not idle
//   done_o                sticky completion flag, cleared by an accepted start
// ---------------------------------------------------------------------------
module cpu_boot_ctrl #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024,
  parameter int RD_LAT     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [9:0]  imem_len_i,
  input  logic [10:0] dmem_len_i,
  input  logic [31:0] run_cycles_i,
  input  logic [10:0] dump_len_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_data_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] m_data_o,
  output logic        cpu_enable_o,
  output logic [31:0] addr_ext_o,
  output logic        wen_ext_o,
  output logic        ren_ext_o,
  output logic [31:0] wdata_ext_o,
  output logic [31:0] addr_ext_2_o,
  output logic        wen_ext_2_o,
  output logic        ren_ext_2_o,
  output logic [31:0] wdata_ext_2_o,
  input  logic [31:0] rdata_ext_2_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_I = 3'd1,
    LOAD_D = 3'd2,
    RUN    = 3'd3,
    DUMP   = 3'd4
  } state_e;

  localparam logic [9:0]  IMEM_MAX = 10'(IMEM_WORDS);
  localparam logic [10:0] DMEM_MAX = 11'(DMEM_WORDS);
  // RD_LAT must be at least 1 (registered memory read)
  localparam int              LAT_W    = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT);

  state_e            state_q, state_d;
  logic [9:0]        imemLen_q, imemLen_d;
  logic [10:0]       dmemLen_q, dmemLen_d;
  logic [31:0]       runLen_q, runLen_d;
  logic [10:0]       dumpLen_q, dumpLen_d;
  logic [10:0]       idx_q, idx_d;
  logic [31:0]       runCnt_q, runCnt_d;
  logic              cpuEn_q, cpuEn_d;
  logic              done_q, done_d;
  logic              wen_q, wen_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wen2_q, wen2_d;
  logic              ren2_q, ren2_d;
  logic [31:0]       addr2_q, addr2_d;
  logic [31:0]       wdata2_q, wdata2_d;
  logic [LAT_W-1:0]  pend_q, pend_d;
  logic              mValid_q, mValid_d;
  logic [31:0]       mData_q, mData_d;

  logic [9:0]  imemClamp;
  logic [10:0] dmemClamp;
  logic [10:0] dumpClamp;
  logic        iNz, dNz, rNz, uNz;
  state_e      nextPhase;
  logic        handshake;
  logic [31:0] byteAddr;

  // Picks the first non-empty phase after 'cur'; empty phases are skipped in
  // the same transition, and running out of phases means back to IDLE.
  function automatic state_e phaseAfter(input state_e cur, input logic iNzA,
                                        input logic dNzA, input logic rNzA,
                                        input logic uNzA);
    state_e nxt;
    nxt = IDLE;
    if (cur == IDLE && iNzA) begin
      nxt = LOAD_I;
    end else if ((cur == IDLE || cur == LOAD_I) && dNzA) begin
      nxt = LOAD_D;
    end else if ((cur == IDLE || cur == LOAD_I || cur == LOAD_D) && rNzA) begin
      nxt = RUN;
    end else if (cur != DUMP && uNzA) begin
      nxt = DUMP;
    end
    return nxt;
  endfunction

  // Length clamping and phase-skip decisions. In IDLE the decision is made on
  // the (clamped) inputs being latched this cycle, elsewhere on the latched copy.
  always_comb begin
    imemClamp = (imem_len_i > IMEM_MAX) ? IMEM_MAX : imem_len_i;
    dmemClamp = (dmem_len_i > DMEM_MAX) ? DMEM_MAX : dmem_len_i;
    dumpClamp = (dump_len_i > DMEM_MAX) ? DMEM_MAX : dump_len_i;
    if (state_q == IDLE) begin
      iNz = (imemClamp != 10'd0);
      dNz = (dmemClamp != 11'd0);
      rNz = (run_cycles_i != 32'd0);
      uNz = (dumpClamp != 11'd0);
    end else begin
      iNz = (imemLen_q != 10'd0);
      dNz = (dmemLen_q != 11'd0);
      rNz = (runLen_q != 32'd0);
      uNz = (dumpLen_q != 11'd0);
    end
    nextPhase = phaseAfter(state_q, iNz, dNz, rNz, uNz);
  end

  assign s_ready_o = (state_q == LOAD_I) || (state_q == LOAD_D);
  assign handshake = s_ready_o && s_valid_i;
  assign byteAddr  = {19'd0, idx_q, 2'b00};

  // Next-state and datapath logic. Memory strobes default low every cycle so
  // each write/read is a single-cycle pulse; everything else holds.
  always_comb begin
    state_d   = state_q;
    imemLen_d = imemLen_q;
    dmemLen_d = dmemLen_q;
    runLen_d  = runLen_q;
    dumpLen_d = dumpLen_q;
    idx_d     = idx_q;
    runCnt_d  = runCnt_q;
    cpuEn_d   = cpuEn_q;
    done_d    = done_q;
    wen_d     = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen2_d    = 1'b0;
    ren2_d    = 1'b0;
    addr2_d   = addr2_q;
    wdata2_d  = wdata2_q;
    pend_d    = pend_q;
    mValid_d  = mValid_q;
    mData_d   = mData_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          imemLen_d = imemClamp;
          dmemLen_d = dmemClamp;
          runLen_d  = run_cycles_i;
          dumpLen_d = dumpClamp;
          idx_d     = 11'd0;
          runCnt_d  = 32'd0;
          state_d   = nextPhase;
          // With every phase empty the sequence completes immediately
          done_d    = (nextPhase == IDLE);
        end
      end

      LOAD_I: begin
        if (handshake) begin
          wen_d   = 1'b1;
          addr_d  = byteAddr;
          wdata_d = s_data_i;
          if (idx_q == ({1'b0, imemLen_q} - 11'd1)) begin
            idx_d   = 11'd0;
            state_d = nextPhase;
            done_d  = (nextPhase == IDLE);
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end

      LOAD_D: begin
        if (handshake) begin
          wen2_d   = 1'b1;
          addr2_d  = byteAddr;
          wdata2_d = s_data_i;
          if (idx_q == (dmemLen_q - 11'd1)) begin
            idx_d   = 11'd0;
            state_d = nextPhase;
            done_d  = (nextPhase == IDLE);
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end

      RUN: begin
        // The first RUN cycle keeps the core disabled so the trailing load
        // write never overlaps an enabled cycle; the enable then stays high
        // for exactly runLen_q cycles.
        if (!cpuEn_q) begin
          cpuEn_d  = 1'b1;
          runCnt_d = 32'd0;
        end else if (runCnt_q == (runLen_q - 32'd1)) begin
          cpuEn_d = 1'b0;
          state_d = nextPhase;
          done_d  = (nextPhase == IDLE);
        end else begin
          runCnt_d = runCnt_q + 32'd1;
        end
      end

      DUMP: begin
        // One read in flight at a time: issue, wait RD_LAT, present, handshake.
        if (mValid_q) begin
          if (m_ready_i) begin
            mValid_d = 1'b0;
            if (idx_q == (dumpLen_q - 11'd1)) begin
              idx_d   = 11'd0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 11'd1;
            end
          end
        end else if (pend_q != '0) begin
          if (pend_q == LAT_W'(1)) begin
            mData_d  = rdata_ext_2_i;
            mValid_d = 1'b1;
            pend_d   = '0;
          end else begin
            pend_d = pend_q - LAT_W'(1);
          end
        end else if (ren2_q) begin
          pend_d = LAT_INIT;
        end else begin
          ren2_d  = 1'b1;
          addr2_d = byteAddr;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to zero / IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      imemLen_q <= '0;
      dmemLen_q <= '0;
      runLen_q  <= '0;
      dumpLen_q <= '0;
      idx_q     <= '0;
      runCnt_q  <= '0;
      cpuEn_q   <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen2_q    <= 1'b0;
      ren2_q    <= 1'b0;
      addr2_q   <= '0;
      wdata2_q  <= '0;
      pend_q    <= '0;
      mValid_q  <= 1'b0;
      mData_q   <= '0;
    end else begin
      state_q   <= state_d;
      imemLen_q <= imemLen_d;
      dmemLen_q <= dmemLen_d;
      runLen_q  <= runLen_d;
      dumpLen_q <= dumpLen_d;
      idx_q     <= idx_d;
      runCnt_q  <= runCnt_d;
      cpuEn_q   <= cpuEn_d;
      done_q    <= done_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen2_q    <= wen2_d;
      ren2_q    <= ren2_d;
      addr2_q   <= addr2_d;
      wdata2_q  <= wdata2_d;
      pend_q    <= pend_d;
      mValid_q  <= mValid_d;
      mData_q   <= mData_d;
    end
  end

  assign m_valid_o     = mValid_q;
  assign m_data_o      = mData_q;
  assign cpu_enable_o  = cpuEn_q;
  assign addr_ext_o    = addr_q;
  assign wen_ext_o     = wen_q;
  assign ren_ext_o     = 1'b0;
  assign wdata_ext_o   = wdata_q;
  assign addr_ext_2_o  = addr2_q;
  assign wen_ext_2_o   = wen2_q;
  assign ren_ext_2_o   = ren2_q;
  assign wdata_ext_2_o = wdata2_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_boot_ctrl
//
// Bench for cpu_boot_ctrl. Models the IMEM/DMEM behind the external ports and
// a tiny core that executes addi/jal while enabled. Expected writes and dump
// words are queued when the load stream is set up and compared against what
// the DUT actually produced.
// ---------------------------------------------------------------------------
module tb_cpu_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  imemLen = '0;
  logic [10:0] dmemLen = '0;
  logic [31:0] runCycles = '0;
  logic [10:0] dumpLen = '0;
  logic        sValid = 1'b0;
  logic        sReady;
  logic [31:0] sData = '0;
  logic        mValid;
  logic        mReady = 1'b0;
  logic [31:0] mData;
  logic        cpuEn;
  logic [31:0] addrExt, wdataExt, addrExt2, wdataExt2;
  logic        wenExt, renExt, wenExt2, renExt2;
  logic [31:0] rdataExt2 = '0;
  logic        busy, done;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] ADDI_X1 = 32'h0010_8093;
  localparam logic [31:0] JAL_M4  = 32'hFFDF_F06F;

  cpu_boot_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .imem_len_i(imemLen), .dmem_len_i(dmemLen),
    .run_cycles_i(runCycles), .dump_len_i(dumpLen),
    .s_valid_i(sValid), .s_ready_o(sReady), .s_data_i(sData),
    .m_valid_o(mValid), .m_ready_i(mReady), .m_data_o(mData),
    .cpu_enable_o(cpuEn),
    .addr_ext_o(addrExt), .wen_ext_o(wenExt), .ren_ext_o(renExt), .wdata_ext_o(wdataExt),
    .addr_ext_2_o(addrExt2), .wen_ext_2_o(wenExt2), .ren_ext_2_o(renExt2),
    .wdata_ext_2_o(wdataExt2), .rdata_ext_2_i(rdataExt2),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // External memories with a one-cycle registered read on the DMEM port
  logic [31:0] imem [0:511];
  logic [31:0] dmem [0:1023];
  always @(posedge clk) begin
    if (wenExt)  imem[addrExt[10:2]]  <= wdataExt;
    if (wenExt2) dmem[addrExt2[11:2]] <= wdataExt2;
    if (renExt2) rdataExt2 <= dmem[addrExt2[11:2]];
  end

  // Minimal core: one addi/jal per enabled cycle, x1 is the loop counter
  logic [31:0] cpuPc, cpuX1, cpuInstr;
  always @(posedge clk) begin
    if (rst) begin
      cpuPc <= '0;
      cpuX1 <= '0;
    end else if (cpuEn) begin
      cpuInstr = imem[cpuPc[10:2]];
      if (cpuInstr[6:0] == 7'h13) begin
        cpuX1 <= cpuX1 + {{20{cpuInstr[31]}}, cpuInstr[31:20]};
        cpuPc <= cpuPc + 32'd4;
      end else if (cpuInstr[6:0] == 7'h6F) begin
        cpuPc <= cpuPc + {{11{cpuInstr[31]}}, cpuInstr[31], cpuInstr[19:12],
                          cpuInstr[20], cpuInstr[30:21], 1'b0};
      end else begin
        cpuPc <= cpuPc + 32'd4;
      end
    end
  end

  // Stimulus / observation state shared by the scenario tasks
  logic [31:0] streamWords[$];
  int          streamIdx;
  bit          bubbleEn = 1'b0;
  logic [3:0]  mrPat = 4'b1111;
  int          mrPtr;
  int          cycleCnt;
  logic [63:0] obsI[$];
  logic [63:0] obsD[$];
  logic [31:0] obsDump[$];
  int          cpuEnCycles, cpuEnRuns, heldCycles, stabViol, strobeViol;
  logic        prevEn, prevHeld;
  logic [31:0] prevData;

  task automatic clear_obs();
    streamWords.delete();
    obsI.delete();
    obsD.delete();
    obsDump.delete();
    streamIdx = 0; mrPtr = 0; cycleCnt = 0;
    cpuEnCycles = 0; cpuEnRuns = 0; heldCycles = 0; stabViol = 0; strobeViol = 0;
    prevEn = 1'b0; prevHeld = 1'b0; prevData = '0;
  endtask

  // One clock: drive just after the rising edge, observe on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (streamIdx < streamWords.size() && !(bubbleEn && (cycleCnt % 2 == 1))) begin
      sValid = 1'b1;
      sData  = streamWords[streamIdx];
    end else begin
      sValid = 1'b0;
      sData  = '0;
    end
    if (mValid) begin
      mReady = mrPat[3 - (mrPtr % 4)];
      mrPtr++;
    end else begin
      mReady = 1'b0;
    end
    @(negedge clk);
    if (wenExt)  obsI.push_back({addrExt, wdataExt});
    if (wenExt2) obsD.push_back({addrExt2, wdataExt2});
    if (cpuEn) begin
      cpuEnCycles++;
      if (!prevEn) cpuEnRuns++;
    end
    prevEn = cpuEn;
    if (renExt || (wenExt2 && renExt2) || (cpuEn && (wenExt || wenExt2 || renExt2)))
      strobeViol++;
    if (sValid && sReady) streamIdx++;
    if (prevHeld && (!mValid || mData !== prevData)) stabViol++;
    if (mValid && mReady) obsDump.push_back(mData);
    if (mValid && !mReady) heldCycles++;
    prevHeld = mValid && !mReady;
    prevData = mData;
    cycleCnt++;
  endtask

  task automatic start_seq(input logic [9:0] i, input logic [10:0] d,
                           input logic [31:0] r, input logic [10:0] u);
    imemLen = i; dmemLen = d; runCycles = r; dumpLen = u;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, done, sReady, mValid, cpuEn, wenExt, wenExt2, renExt, renExt2} !== 9'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b want 000000000",
               {busy, done, sReady, mValid, cpuEn, wenExt, wenExt2, renExt, renExt2});
    end
    vectors++;
    if ({addrExt, wdataExt, addrExt2, wdataExt2, mData} !== 160'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_buses: got %h %h %h %h %h want all 0",
               addrExt, wdataExt, addrExt2, wdataExt2, mData);
    end
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic test_all_zero();
    do_reset();
    start_seq(10'd0, 11'd0, 32'd0, 11'd0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL all_zero_done: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
  endtask

  task automatic test_load();
    logic [63:0] expI[$];
    logic [63:0] expD[$];
    logic [63:0] e, o;
    bit ok;
    do_reset();
    streamWords = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D, 32'hE000_000E};
    expI = '{{32'h0, 32'hA000_000A}, {32'h4, 32'hB000_000B}, {32'h8, 32'hC000_000C}};
    expD = '{{32'h0, 32'hD000_000D}, {32'h4, 32'hE000_000E}};
    start_seq(10'd3, 11'd2, 32'd0, 11'd0);
    wait_idle(100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL load_timeout: got busy=%b want idle", busy); end
    vectors++;
    if (obsI.size() != 3 || obsD.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL load_count: got imem=%0d dmem=%0d want 3 2", obsI.size(), obsD.size());
    end
    while (expI.size() > 0 && obsI.size() > 0) begin
      e = expI.pop_front(); o = obsI.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL load_imem_wr: got %h want %h", o, e); end
    end
    while (expD.size() > 0 && obsD.size() > 0) begin
      e = expD.pop_front(); o = obsD.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL load_dmem_wr: got %h want %h", o, e); end
    end
    vectors++;
    if (done !== 1'b1 || cpuEnCycles != 0 || strobeViol != 0) begin
      miscompares++;
      $display("[TB] FAIL load_end: got done=%b en=%0d viol=%0d want 1 0 0", done, cpuEnCycles, strobeViol);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] expDump[$];
    logic [31:0] e, o;
    bit ok;
    do_reset();
    streamWords = '{32'd10, 32'd20, 32'd30, 32'd40};
    expDump     = '{32'd10, 32'd20, 32'd30, 32'd40};
    mrPat = 4'b1010;
    start_seq(10'd0, 11'd4, 32'd0, 11'd4);
    wait_idle(300, ok);
    mrPat = 4'b1111;
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL bp_timeout: got busy=%b want idle", busy); end
    vectors++;
    if (obsDump.size() != 4) begin
      miscompares++; $display("[TB] FAIL bp_count: got %0d want 4", obsDump.size());
    end
    while (expDump.size() > 0 && obsDump.size() > 0) begin
      e = expDump.pop_front(); o = obsDump.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL bp_data: got %0d want %0d", o, e); end
    end
    vectors++;
    if (heldCycles != 3 || stabViol != 0 || strobeViol != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: got held=%0d unstable=%0d viol=%0d want 3 0 0",
               heldCycles, stabViol, strobeViol);
    end
  endtask

  task automatic test_run_window();
    bit ok;
    do_reset();
    streamWords = '{ADDI_X1, JAL_M4};
    start_seq(10'd2, 11'd0, 32'd5, 11'd0);
    wait_idle(100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL run_timeout: got busy=%b want idle", busy); end
    vectors++;
    if (cpuEnCycles != 5 || cpuEnRuns != 1) begin
      miscompares++;
      $display("[TB] FAIL run_enable: got cycles=%0d runs=%0d want 5 1", cpuEnCycles, cpuEnRuns);
    end
    vectors++;
    if (cpuX1 !== 32'((5 + 1) / 2)) begin
      miscompares++; $display("[TB] FAIL run_counter: got %0d want %0d", cpuX1, (5 + 1) / 2);
    end
    vectors++;
    if (strobeViol != 0 || obsI.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL run_strobes: got viol=%0d writes=%0d want 0 2", strobeViol, obsI.size());
    end
  endtask

  task automatic test_clamp();
    logic [31:0] words[$];
    logic [63:0] o;
    logic [31:0] lastAddr;
    bit ok;
    do_reset();
    for (int i = 0; i < 513; i++) words.push_back(32'h5A00_0000 + 32'(i));
    streamWords = words;
    start_seq(10'd600, 11'd1, 32'd0, 11'd0);
    wait_idle(2000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL clamp_timeout: got busy=%b want idle", busy); end
    vectors++;
    if (obsI.size() != 512) begin
      miscompares++; $display("[TB] FAIL clamp_count: got %0d want 512", obsI.size());
    end
    lastAddr = (obsI.size() > 0) ? obsI[obsI.size() - 1][63:32] : 32'hFFFF_FFFF;
    vectors++;
    if (lastAddr !== 32'h7FC) begin
      miscompares++; $display("[TB] FAIL clamp_last_addr: got %h want 000007fc", lastAddr);
    end
    for (int i = 0; i < 512 && obsI.size() > 0; i++) begin
      o = obsI.pop_front();
      vectors++;
      if (o !== {32'(i * 4), words[i]}) begin
        miscompares++; $display("[TB] FAIL clamp_wr: got %h want %h", o, {32'(i * 4), words[i]});
      end
    end
    vectors++;
    if (obsD.size() != 1 || obsD[0] !== {32'h0, words[512]}) begin
      miscompares++;
      $display("[TB] FAIL clamp_then_dmem: got n=%0d want one write %h", obsD.size(), {32'h0, words[512]});
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    do_reset();
    start_seq(10'd0, 11'd0, 32'd10, 11'd0);
    for (int c = 0; c < 50 && cpuEnCycles < 2; c++) tick();
    tick();
    vectors++;
    if (cpuEn !== 1'b1 || cpuEnCycles != 3) begin
      miscompares++;
      $display("[TB] FAIL midrun_reach: got en=%b cycles=%0d want 1 3", cpuEn, cpuEnCycles);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (cpuEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || renExt2 !== 1'b0 || mValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset: got en=%b busy=%b done=%b want 0 0 0", cpuEn, busy, done);
    end
    clear_obs();
    streamWords = '{32'hCAFE_0001};
    start_seq(10'd0, 11'd1, 32'd0, 11'd1);
    wait_idle(100, ok);
    vectors++;
    if (!ok || done !== 1'b1) begin
      miscompares++; $display("[TB] FAIL midrun_restart: got done=%b want 1", done);
    end
    vectors++;
    if (obsDump.size() != 1 || obsDump[0] !== 32'hCAFE_0001) begin
      miscompares++;
      $display("[TB] FAIL midrun_dump: got n=%0d want one word cafe0001", obsDump.size());
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] expD[$];
    logic [31:0] expDump[$];
    logic [63:0] e, o;
    logic [31:0] ed, od;
    bit ok;
    do_reset();
    streamWords = '{32'h1111_0000, 32'h1111_0001, 32'h2222_0000, 32'h2222_0001, 32'h2222_0002};
    expD    = '{{32'h0, 32'h2222_0000}, {32'h4, 32'h2222_0001}, {32'h8, 32'h2222_0002}};
    expDump = '{32'h2222_0000, 32'h2222_0001};
    bubbleEn = 1'b1;
    start_seq(10'd2, 11'd3, 32'd0, 11'd2);
    for (int c = 0; c < 50 && streamIdx < 3; c++) tick();
    imemLen = 10'd7; dmemLen = 11'd9; runCycles = 32'd4; dumpLen = 11'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(300, ok);
    bubbleEn = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL ignore_timeout: got busy=%b want idle", busy); end
    vectors++;
    if (obsI.size() != 2 || obsD.size() != 3 || cpuEnCycles != 0) begin
      miscompares++;
      $display("[TB] FAIL ignore_counts: got imem=%0d dmem=%0d en=%0d want 2 3 0",
               obsI.size(), obsD.size(), cpuEnCycles);
    end
    while (expD.size() > 0 && obsD.size() > 0) begin
      e = expD.pop_front(); o = obsD.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL ignore_dmem_wr: got %h want %h", o, e); end
    end
    vectors++;
    if (obsDump.size() != 2) begin
      miscompares++; $display("[TB] FAIL ignore_dump_count: got %0d want 2", obsDump.size());
    end
    while (expDump.size() > 0 && obsDump.size() > 0) begin
      ed = expDump.pop_front(); od = obsDump.pop_front();
      vectors++;
      if (od !== ed) begin miscompares++; $display("[TB] FAIL ignore_dump: got %h want %h", od, ed); end
    end
  endtask

  // Hard stop in case a scenario wedges outside its own cycle budgets
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_obs();
    test_reset();
    test_all_zero();
    test_load();
    test_backpressure();
    test_run_window();
    test_clamp();
    test_reset_mid_run();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
